// File: rtl/aximm_csr_test_seq.sv
// rtl/aximm_csr_test_seq.sv - CSR sequencer that runs the AXI-MM-over-AIB loopback self-test
// Optional DOUT/DIN first/last word compare after REPORT: define AXIMM_CSR_SEQ_CHECK_EN.
module aximm_csr_test_seq #(
  parameter logic [31:0] DLY_X      = 32'h0000000C,
  parameter logic [31:0] DLY_Y      = 32'h00000020,
  parameter logic [31:0] DLY_Z      = 32'h00001770,
  parameter logic [31:0] BURST_ADDR = 32'h10000000,
  parameter logic [31:0] BURST_CFG  = 32'h00041804,
  parameter int          POLL_GAP   = 16,
  parameter int          POLL_MAX   = 4096,
  parameter int          RESP_MAX   = 256
) (
  input  logic        avmm_clk,
  input  logic        i_avmm_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_fail,
  output logic        o_timeout,
  output logic [3:0]  o_state,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wrdata,
  output logic        o_wren,
  output logic        o_rden,
  input  logic [31:0] i_master_readdata,
  input  logic        i_master_readdatavalid,
  input  logic        i_master_waitrequest
);

  localparam logic [31:0] A_DLY_X = 32'h50002000;
  localparam logic [31:0] A_DLY_Y = 32'h50002004;
  localparam logic [31:0] A_DLY_Z = 32'h50002008;
  localparam logic [31:0] A_WRCFG = 32'h50001000;
  localparam logic [31:0] A_MMADR = 32'h50001004;
  localparam logic [31:0] A_STAT  = 32'h50001008;
  localparam logic [31:0] A_LINK  = 32'h5000100C;
  localparam logic [31:0] A_RDCFG = 32'h50001010;

  // Counters run 0..N-1, so clog2(N) bits suffice.
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam int RW = (RESP_MAX > 1) ? $clog2(RESP_MAX) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [RW-1:0] RESP_LAST = RW'(RESP_MAX - 1);

`ifdef AXIMM_CSR_SEQ_CHECK_EN
  localparam logic [31:0] A_DOUT_F = 32'h50004000;
  localparam logic [31:0] A_DOUT_L = 32'h50004010;
  localparam logic [31:0] A_DIN_F  = 32'h50004020;
  localparam logic [31:0] A_DIN_L  = 32'h50004030;
  typedef enum logic [4:0] {
    IDLE, CFG_X, CFG_Y, CFG_Z, LINK_POLL, LINK_GAP, WR_ADDR, WR_GO, WR_POLL,
    RD_ADDR, RD_GO, RD_POLL, REPORT, DONE, ERR, CHK_OF, CHK_IF, CHK_OL, CHK_IL
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, CFG_X, CFG_Y, CFG_Z, LINK_POLL, LINK_GAP, WR_ADDR, WR_GO, WR_POLL,
    RD_ADDR, RD_GO, RD_POLL, REPORT, DONE, ERR
  } state_t;
`endif

  // Each op-carrying state walks ISSUE -> END (write) or ISSUE -> WAIT -> EVAL (read).
  typedef enum logic [2:0] {PH_ISSUE, PH_END, PH_WAIT, PH_EVAL, PH_GAP} phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [RW-1:0] resp_q, resp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic          tmo_q, tmo_d;
`ifdef AXIMM_CSR_SEQ_CHECK_EN
  logic [31:0]   cmp_q, cmp_d;
  logic          unused_state;
  assign unused_state = state_q[4];
`else
  logic          unused_rdata;
  assign unused_rdata = ^rdata_q[31:6];
`endif

  logic [31:0] op_addr;
  logic [31:0] op_data;
  logic        op_wr;
  logic        op_rd;
  logic        wr_end;
  logic        rd_end;
  logic        poll_last;

  always_comb begin
    op_addr = '0;
    op_data = '0;
    op_wr   = 1'b0;
    op_rd   = 1'b0;
    case (state_q)
      CFG_X:   begin op_addr = A_DLY_X; op_data = DLY_X;      op_wr = 1'b1; end
      CFG_Y:   begin op_addr = A_DLY_Y; op_data = DLY_Y;      op_wr = 1'b1; end
      CFG_Z:   begin op_addr = A_DLY_Z; op_data = DLY_Z;      op_wr = 1'b1; end
      WR_ADDR: begin op_addr = A_MMADR; op_data = BURST_ADDR; op_wr = 1'b1; end
      WR_GO:   begin op_addr = A_WRCFG; op_data = BURST_CFG;  op_wr = 1'b1; end
      RD_ADDR: begin op_addr = A_MMADR; op_data = BURST_ADDR; op_wr = 1'b1; end
      RD_GO:   begin op_addr = A_RDCFG; op_data = BURST_CFG;  op_wr = 1'b1; end
      LINK_POLL:                begin op_addr = A_LINK; op_rd = 1'b1; end
      WR_POLL, RD_POLL, REPORT: begin op_addr = A_STAT; op_rd = 1'b1; end
`ifdef AXIMM_CSR_SEQ_CHECK_EN
      CHK_OF:  begin op_addr = A_DOUT_F; op_rd = 1'b1; end
      CHK_IF:  begin op_addr = A_DIN_F;  op_rd = 1'b1; end
      CHK_OL:  begin op_addr = A_DOUT_L; op_rd = 1'b1; end
      CHK_IL:  begin op_addr = A_DIN_L;  op_rd = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign wr_end    = (phase_q == PH_END);
  assign rd_end    = (phase_q == PH_EVAL);
  assign poll_last = (poll_q == POLL_LAST);

  assign o_wr_addr = op_addr;
  assign o_wrdata  = op_data;
  assign o_wren    = op_wr & (phase_q == PH_ISSUE);
  assign o_rden    = op_rd & (phase_q == PH_ISSUE);
  assign o_busy    = (state_q != IDLE) && (state_q != DONE);
  assign o_done    = (state_q == DONE);
  assign o_pass    = pass_q;
  assign o_fail    = fail_q;
  assign o_timeout = tmo_q;
  assign o_state   = state_q[3:0];

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    poll_d  = poll_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
`ifdef AXIMM_CSR_SEQ_CHECK_EN
    cmp_d   = cmp_q;
`endif

    case (phase_q)
      PH_ISSUE: if ((op_wr || op_rd) && !i_master_waitrequest) begin
        phase_d = op_wr ? PH_END : PH_WAIT;
        resp_d  = '0;
      end
      PH_WAIT: begin
        if (i_master_readdatavalid) begin
          rdata_d = i_master_readdata;
          phase_d = PH_EVAL;
        end else if (resp_q == RESP_LAST) begin
          state_d = ERR;
          phase_d = PH_ISSUE;
        end else begin
          resp_d = resp_q + 1'b1;
        end
      end
      PH_GAP: begin
        if (gap_q == GAP_LAST) phase_d = PH_ISSUE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: ;
    endcase

    // The decode cycle after readdatavalid counts as the first idle gap cycle.
    case (state_q)
      IDLE, DONE: if (i_start) begin
        state_d = CFG_X;
        phase_d = PH_ISSUE;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        tmo_d   = 1'b0;
      end
      CFG_X:   if (wr_end) begin state_d = CFG_Y;   phase_d = PH_ISSUE; end
      CFG_Y:   if (wr_end) begin state_d = CFG_Z;   phase_d = PH_ISSUE; end
      CFG_Z:   if (wr_end) begin state_d = LINK_POLL; phase_d = PH_ISSUE; poll_d = '0; end
      LINK_POLL: if (rd_end) begin
        phase_d = PH_ISSUE;
        if (rdata_q[3:0] == 4'hF) state_d = WR_ADDR;
        else if (poll_last)       state_d = ERR;
        else begin
          poll_d  = poll_q + 1'b1;
          gap_d   = GW'(1);
          state_d = (POLL_GAP > 1) ? LINK_GAP : LINK_POLL;
        end
      end
      LINK_GAP: begin
        if (gap_q == GAP_LAST) state_d = LINK_POLL;
        else                   gap_d   = gap_q + 1'b1;
      end
      WR_ADDR: if (wr_end) begin state_d = WR_GO;   phase_d = PH_ISSUE; end
      WR_GO:   if (wr_end) begin state_d = WR_POLL; phase_d = PH_ISSUE; poll_d = '0; end
      WR_POLL: if (rd_end) begin
        if (rdata_q[4])     begin state_d = RD_ADDR; phase_d = PH_ISSUE; end
        else if (poll_last) begin state_d = ERR;     phase_d = PH_ISSUE; end
        else begin
          poll_d  = poll_q + 1'b1;
          gap_d   = GW'(1);
          phase_d = (POLL_GAP > 1) ? PH_GAP : PH_ISSUE;
        end
      end
      RD_ADDR: if (wr_end) begin state_d = RD_GO;   phase_d = PH_ISSUE; end
      RD_GO:   if (wr_end) begin state_d = RD_POLL; phase_d = PH_ISSUE; poll_d = '0; end
      RD_POLL: if (rd_end) begin
        if (rdata_q[5])     begin state_d = REPORT; phase_d = PH_ISSUE; end
        else if (poll_last) begin state_d = ERR;    phase_d = PH_ISSUE; end
        else begin
          poll_d  = poll_q + 1'b1;
          gap_d   = GW'(1);
          phase_d = (POLL_GAP > 1) ? PH_GAP : PH_ISSUE;
        end
      end
      REPORT: if (rd_end) begin
        phase_d = PH_ISSUE;
        if (rdata_q[3:0] == 4'hF) begin
          pass_d  = 1'b1;
`ifdef AXIMM_CSR_SEQ_CHECK_EN
          state_d = CHK_OF;
`else
          state_d = DONE;
`endif
        end else begin
          fail_d  = 1'b1;
          state_d = DONE;
        end
      end
      ERR: begin
        tmo_d   = 1'b1;
        fail_d  = 1'b1;
        pass_d  = 1'b0;
        state_d = DONE;
      end
`ifdef AXIMM_CSR_SEQ_CHECK_EN
      CHK_OF: if (rd_end) begin cmp_d = rdata_q; state_d = CHK_IF; phase_d = PH_ISSUE; end
      CHK_IF: if (rd_end) begin
        if (rdata_q != cmp_q) begin pass_d = 1'b0; fail_d = 1'b1; end
        state_d = CHK_OL;
        phase_d = PH_ISSUE;
      end
      CHK_OL: if (rd_end) begin cmp_d = rdata_q; state_d = CHK_IL; phase_d = PH_ISSUE; end
      CHK_IL: if (rd_end) begin
        if (rdata_q != cmp_q) begin pass_d = 1'b0; fail_d = 1'b1; end
        state_d = DONE;
        phase_d = PH_ISSUE;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge avmm_clk or posedge i_avmm_rst) begin
    if (i_avmm_rst) begin
      state_q <= IDLE;
      phase_q <= PH_ISSUE;
      gap_q   <= '0;
      poll_q  <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef AXIMM_CSR_SEQ_CHECK_EN
      cmp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
`ifdef AXIMM_CSR_SEQ_CHECK_EN
      cmp_q   <= cmp_d;
`endif
    end
  end

endmodule

// File: doc/aximm_csr_test_seq.md
Name: aximm_csr_test_seq

Overview:
- Hardware sequencer that drives the AXI-MM-over-AIB top-level CSR port (i_wr_addr/i_wrdata/i_wren/i_rden, readdata/readdatavalid/waitrequest).
- Runs the self-test bring-up in fixed order: program delay X/Y/Z, poll link-up, launch the write burst, poll write-done, launch the read burst, poll read-done, read the result.
- Lets silicon and emulation run the loopback test with no external CSR host; a single pass/fail pair is reported.

Parameters:
- DLY_X, 32'h0000000C, value written to 0x50002000
- DLY_Y, 32'h00000020, value written to 0x50002004
- DLY_Z, 32'h00001770, value written to 0x50002008
- BURST_ADDR, 32'h10000000, value written to REG_MM_WR_RD (0x50001004)
- BURST_CFG, 32'h00041804, value written to WR_CFG (0x50001000) and RD_CFG (0x50001010)
- POLL_GAP, 16, idle cycles between successive status reads (min 1)
- POLL_MAX, 4096, status reads allowed per poll state before timeout
- RESP_MAX, 256, cycles allowed from rden acceptance to readdatavalid

Ports:
- avmm_clk, in, 1, sequencer clock; same clock as the CSR port
- i_avmm_rst, in, 1, asynchronous active-high reset
- i_start, in, 1, one-cycle start pulse; sampled only in IDLE or DONE
- o_busy, out, 1, high from start acceptance until DONE
- o_done, out, 1, sticky; sequence finished (pass, fail or timeout)
- o_pass, out, 1, sticky; REPORT read 4'hF in bits [3:0]
- o_fail, out, 1, sticky; REPORT read anything else, or timeout
- o_timeout, out, 1, sticky; a poll or response limit was exceeded
- o_state, out, 4, current state encoding (debug)
- o_wr_addr, out, 32, CSR address
- o_wrdata, out, 32, CSR write data
- o_wren, out, 1, CSR write strobe
- o_rden, out, 1, CSR read strobe
- i_master_readdata, in, 32, CSR read data
- i_master_readdatavalid, in, 1, read data qualifier
- i_master_waitrequest, in, 1, stall; strobe is held while high

Behaviour:
- Reset: state IDLE; every output 0; all counters 0. Reset mid-sequence aborts immediately; no CSR strobe is issued afterwards.
- CSR write op: drive address, data and o_wren=1. The op is accepted on the first edge with waitrequest=0; strobe drops the next cycle.
- CSR read op: drive address and o_rden=1 until accepted the same way. Then wait for readdatavalid and latch readdata. If readdatavalid has not arrived RESP_MAX cycles after acceptance, go to ERR.
- Only one op is outstanding at a time. Strobes are never asserted together.
- States in order:
  - IDLE
  - CFG_X, CFG_Y, CFG_Z: writes
  - LINK_POLL: read 0x5000100C; bits [3:0]==4'hF advances, else LINK_GAP
  - LINK_GAP: POLL_GAP idle cycles, then back to LINK_POLL
  - WR_ADDR: write BURST_ADDR
  - WR_GO: write BURST_CFG to 0x50001000
  - WR_POLL: read 0x50001008; bit4 advances, else gap
  - RD_ADDR: write BURST_ADDR
  - RD_GO: write BURST_CFG to 0x50001010
  - RD_POLL: read 0x50001008; bit5 advances, else gap
  - REPORT: read 0x50001008
  - DONE
  - ERR
- Gaps in WR_POLL and RD_POLL reuse the LINK_GAP counter.
- Poll counter: cleared on entering each poll state, incremented per completed read. When it reaches POLL_MAX without success, go to ERR.
- REPORT: bits [3:0]==4'hF sets o_pass, otherwise sets o_fail. Then DONE.
- ERR: sets o_timeout and o_fail, then DONE.
- DONE: o_busy=0, o_done=1.
- i_start in IDLE or DONE clears done/pass/fail/timeout and enters CFG_X next cycle (o_busy=1 that cycle). i_start in any other state is ignored.
- Status bits that set in a poll read's data are acted on in the cycle after readdatavalid.

Optional Feature:
- AXIMM_CSR_SEQ_CHECK_EN defined: after REPORT passes, the sequencer reads 0x50004000 (DOUT_FIRST word 0) and 0x50004020 (DIN_FIRST word 0), then 0x50004010 and 0x50004030 (LAST).
  - Any first or last mismatch clears o_pass and sets o_fail.
  - Adds states CHK_OF, CHK_IF, CHK_OL, CHK_IL.
- Undefined: REPORT goes directly to DONE; these states and their compare registers do not exist.

Test Plan:
- Ideal slave (no waitrequest, readdatavalid 2 cycles after rden; link reads 4'h0 three times then 4'hF; bit4 after 2 polls; bit5 after 1 poll; REPORT returns 0xF). Pulse i_start. Required:
  - writes appear in exact order with exact addr/data: DLY_X, DLY_Y, DLY_Z, BURST_ADDR, BURST_CFG@1000, BURST_ADDR, BURST_CFG@1010
  - exactly POLL_GAP idle cycles between polls
  - o_pass=1, o_done=1, o_busy=0
- REPORT returns 0xE -> o_fail=1, o_pass=0, o_timeout=0.
- Link never reaches 4'hF, POLL_MAX=8 -> exactly 8 link reads, then o_timeout=1, o_fail=1. WR_GO is never issued.
- waitrequest held 5 cycles on the CFG_Y write -> o_wren stays high for 6 cycles with stable addr/data. Exactly one write is accepted; the sequence completes with pass.
- readdatavalid withheld, RESP_MAX=16 -> ERR 16 cycles after rden acceptance, o_timeout=1.
- i_avmm_rst asserted during WR_POLL -> all outputs 0 asynchronously; o_state=IDLE. A new i_start reruns from CFG_X. i_start pulsed while busy -> no effect on the op sequence.
